// File: rtl/stage_latch_pkg.sv
// Shared pipeline defaults and the main-entry load-source encoding used by stage_latch.
package stage_latch_pkg;

  localparam int unsigned PIPE_WIDTH     = 32;
  localparam int unsigned PIPE_FIELDS    = 4;
  localparam int unsigned PIPE_NOP_FIELD = 1;
  localparam logic [31:0] PIPE_NOP       = 32'h0000_0000;

  typedef enum logic [1:0] {
    SRC_HOLD  = 2'd0,
    SRC_SKID  = 2'd1,
    SRC_IN    = 2'd2,
    SRC_CLEAR = 2'd3
  } main_src_e;

endpackage

// File: rtl/stage_latch_entry_reg.sv
// One pipeline entry: packed data plus valid bit, loaded when en is high.
module entry_reg #(
  parameter int unsigned DW = 128
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          en,
  input  logic          d_valid,
  input  logic [DW-1:0] d_data,
  output logic          q_valid,
  output logic [DW-1:0] q_data
);

  logic          valid_q, valid_d;
  logic [DW-1:0] data_q, data_d;

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (en) begin
      valid_d = d_valid;
      data_d  = d_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign q_valid = valid_q;
  assign q_data  = data_q;

endmodule

// File: rtl/stage_latch.sv
// Two-entry pipeline stage (main + skid) with registered in_ready, flush,
// bubble insertion on empty output and a saturating stall counter.
module stage_latch
  import stage_latch_pkg::*;
#(
  parameter int unsigned       WIDTH     = PIPE_WIDTH,
  parameter int unsigned       FIELDS    = PIPE_FIELDS,
  parameter int unsigned       NOP_FIELD = PIPE_NOP_FIELD,
  parameter logic [WIDTH-1:0]  NOP_VALUE = WIDTH'(PIPE_NOP)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    flush,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [FIELDS*WIDTH-1:0] in_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [FIELDS*WIDTH-1:0] out_data,
  output logic [15:0]             stall_count
);

  localparam int unsigned DW = FIELDS * WIDTH;

  logic          main_en, main_d_valid, main_valid;
  logic [DW-1:0] main_d_data, main_data;
  logic          skid_en, skid_d_valid, skid_valid;
  logic [DW-1:0] skid_d_data, skid_data;

  logic          accept;
  logic          main_free;
  main_src_e     main_src;
  logic [DW-1:0] bubble;
  logic [15:0]   stall_q, stall_d;

  // in_ready comes straight from the skid valid flop, so out_ready never reaches it
  assign in_ready  = ~skid_valid;
  assign accept    = in_valid & in_ready;
  assign main_free = ~main_valid | out_ready;

  always_comb begin
    main_src = SRC_HOLD;
    if (flush)           main_src = SRC_CLEAR;
    else if (main_free) begin
      if (skid_valid)    main_src = SRC_SKID;
      else if (accept)   main_src = SRC_IN;
      else               main_src = SRC_CLEAR;
    end
  end

  always_comb begin
    main_en      = 1'b0;
    main_d_valid = 1'b0;
    main_d_data  = main_data;
    case (main_src)
      SRC_SKID: begin
        main_en      = 1'b1;
        main_d_valid = 1'b1;
        main_d_data  = skid_data;
      end
      SRC_IN: begin
        main_en      = 1'b1;
        main_d_valid = 1'b1;
        main_d_data  = in_data;
      end
      SRC_CLEAR: begin
        main_en      = 1'b1;
        main_d_valid = 1'b0;
      end
      default: begin
        main_en      = 1'b0;
        main_d_valid = main_valid;
      end
    endcase
  end

  always_comb begin
    skid_en      = 1'b0;
    skid_d_valid = skid_valid;
    skid_d_data  = skid_data;
    if (flush) begin
      skid_en      = 1'b1;
      skid_d_valid = 1'b0;
    end else if (main_free && skid_valid) begin
      skid_en      = 1'b1;
      skid_d_valid = 1'b0;
    end else if (!main_free && accept) begin
      skid_en      = 1'b1;
      skid_d_valid = 1'b1;
      skid_d_data  = in_data;
    end
  end

  entry_reg #(.DW(DW)) u_main (
    .clk     (clk),
    .rst_n   (reset),
    .en      (main_en),
    .d_valid (main_d_valid),
    .d_data  (main_d_data),
    .q_valid (main_valid),
    .q_data  (main_data)
  );

  entry_reg #(.DW(DW)) u_skid (
    .clk     (clk),
    .rst_n   (reset),
    .en      (skid_en),
    .d_valid (skid_d_valid),
    .d_data  (skid_d_data),
    .q_valid (skid_valid),
    .q_data  (skid_data)
  );

  always_comb begin
    bubble = '0;
    bubble[NOP_FIELD*WIDTH +: WIDTH] = NOP_VALUE;
  end

  assign out_valid = main_valid;
  assign out_data  = main_valid ? main_data : bubble;

  always_comb begin
    stall_d = stall_q;
    if (main_valid && !out_ready && (stall_q != 16'hFFFF))
      stall_d = stall_q + 16'd1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) stall_q <= 16'd0;
    else        stall_q <= stall_d;
  end

  assign stall_count = stall_q;

endmodule

// File: tb/tb_stage_latch.sv
// Directed scoreboard bench for stage_latch.
module tb_stage_latch;

  localparam int unsigned W   = 32;
  localparam int unsigned F   = 4;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic           clk = 1'b0;
  logic           reset;
  logic           flush;
  logic           in_valid;
  logic           in_ready;
  logic [F*W-1:0] in_data;
  logic           out_valid;
  logic           out_ready;
  logic [F*W-1:0] out_data;
  logic [15:0]    stall_count;

  int total = 0;
  int bad   = 0;
  logic [F*W-1:0] sb_q[$];
  logic [F*W-1:0] exp_v;
  logic [F*W-1:0] bubble_v;

  stage_latch #(.WIDTH(W), .FIELDS(F), .NOP_FIELD(1), .NOP_VALUE(NOP)) dut (
    .clk         (clk),
    .reset       (reset),
    .flush       (flush),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_data     (in_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data),
    .stall_count (stall_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [F*W-1:0] obs, input logic [F*W-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [F*W-1:0] mk(input int k);
    logic [F*W-1:0] e;
    e = {32'(k * 3), 32'(k * 2), 32'h1000_0000 + 32'(k), 32'(k)};
    return e;
  endfunction

  // Scoreboard bookkeeping happens just before the edge, then time moves to 1 after it.
  task automatic tick();
    if (flush) begin
      sb_q.delete();
    end else begin
      if (out_valid && out_ready) begin
        if (sb_q.size() == 0) begin
          check("sb_underflow", out_data, bubble_v ^ {F*W{1'b1}});
        end else begin
          exp_v = sb_q.pop_front();
          check("sb_data", out_data, exp_v);
        end
      end
      if (in_valid && in_ready) sb_q.push_back(in_data);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    bubble_v = '0;
    bubble_v[W +: W] = NOP;
    reset = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_data = '0;
    #12;
    check("rst_out_valid", F*W'(out_valid), F*W'(1'b0));
    check("rst_in_ready", F*W'(in_ready), F*W'(1'b1));
    check("rst_stall", F*W'(stall_count), F*W'(16'd0));
    check("rst_bubble", out_data, bubble_v);
    reset = 1'b1;
    @(posedge clk); #1;

    // single entry, one-cycle latency
    in_data = {32'd9, 32'd7, 32'h1234_5678, 32'd5};
    in_valid = 1'b1; out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    check("single_valid", F*W'(out_valid), F*W'(1'b1));
    check("single_data", out_data, {32'd9, 32'd7, 32'h1234_5678, 32'd5});
    tick();
    check("single_drained", F*W'(out_valid), F*W'(1'b0));

    // back-to-back streaming
    for (int k = 1; k <= 10; k++) begin
      in_data = mk(k); in_valid = 1'b1;
      tick();
      check("b2b_valid", F*W'(out_valid), F*W'(1'b1));
      check("b2b_in_ready", F*W'(in_ready), F*W'(1'b1));
      check("b2b_order", out_data, mk(k));
    end
    in_valid = 1'b0;
    tick();
    check("b2b_empty", F*W'(sb_q.size()), '0);

    // fill main and skid, then drain
    out_ready = 1'b0;
    in_data = mk(1); in_valid = 1'b1; tick();
    in_data = mk(2); tick();
    in_valid = 1'b0;
    check("skid_main_data", out_data, mk(1));
    check("skid_in_ready", F*W'(in_ready), F*W'(1'b0));
    check("skid_stall", F*W'(stall_count), F*W'(16'd1));
    tick();
    check("skid_hold", out_data, mk(1));
    out_ready = 1'b1;
    tick();
    check("skid_second", out_data, mk(2));
    check("skid_ready_back", F*W'(in_ready), F*W'(1'b1));
    tick();
    check("skid_done", F*W'(out_valid), F*W'(1'b0));
    check("skid_stall2", F*W'(stall_count), F*W'(16'd2));

    // flush with both entries full and a new entry offered
    out_ready = 1'b0;
    in_data = mk(3); in_valid = 1'b1; tick();
    in_data = mk(4); tick();
    check("pre_flush_full", F*W'(in_ready), F*W'(1'b0));
    in_data = mk(5); flush = 1'b1; tick();
    flush = 1'b0; in_valid = 1'b0;
    check("flush_valid", F*W'(out_valid), F*W'(1'b0));
    check("flush_bubble", out_data, bubble_v);
    check("flush_ready", F*W'(in_ready), F*W'(1'b1));
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("flush_no_old", F*W'(out_valid), F*W'(1'b0));
    end

    // stall counter saturation
    out_ready = 1'b0;
    in_data = mk(6); in_valid = 1'b1; tick();
    in_valid = 1'b0;
    for (int i = 0; i < 70000; i++) tick();
    check("stall_sat", F*W'(stall_count), F*W'(16'hFFFF));
    flush = 1'b1; tick(); flush = 1'b0;
    check("stall_after_flush", F*W'(stall_count), F*W'(16'hFFFF));
    check("sat_flush_valid", F*W'(out_valid), F*W'(1'b0));

    // asynchronous reset mid-stream with skid full
    in_data = mk(7); in_valid = 1'b1; tick();
    in_data = mk(8); tick();
    in_valid = 1'b0;
    check("pre_rst_full", F*W'(in_ready), F*W'(1'b0));
    #2 reset = 1'b0;
    #1;
    check("arst_valid", F*W'(out_valid), F*W'(1'b0));
    check("arst_ready", F*W'(in_ready), F*W'(1'b1));
    check("arst_stall", F*W'(stall_count), F*W'(16'd0));
    check("arst_bubble", out_data, bubble_v);
    sb_q.delete();
    @(negedge clk);
    reset = 1'b1;
    in_data = mk(9); in_valid = 1'b1; out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    check("post_rst_accept", F*W'(out_valid), F*W'(1'b1));
    check("post_rst_data", out_data, mk(9));
    tick();
    check("final_empty", F*W'(sb_q.size()), '0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
